// File: rtl/inst_prefetch_buffer_pkg.sv
// rtl/inst_prefetch_buffer_pkg.sv - shared constants, types and helpers for the prefetch buffer
package inst_prefetch_buffer_pkg;

    localparam int DEPTH_DEFAULT  = 4;
    localparam int ADDR_W_DEFAULT = 12;

    // Canonical RISC-V no-op (addi x0, x0, 0)
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Pointer width for a power-of-two FIFO of the given depth
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One buffered instruction together with the byte address it was fetched from
    typedef struct packed {
        logic [31:0]               inst;
        logic [ADDR_W_DEFAULT-1:0] pc;
    } entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_fifo.sv
// rtl/inst_prefetch_buffer_fifo.sv - synchronous FIFO with flush, occupancy count and registered head
module inst_fifo
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int W     = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    push_i,
    input  logic [W-1:0]            push_data_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output logic [ptr_w(DEPTH):0]   count_o,
    output logic                    head_valid_o,
    output logic [W-1:0]            head_data_o
);

    localparam int PW = ptr_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // Flush and reset both discard whatever is being written this cycle
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    // Entry storage needs no reset; occupancy decides what is meaningful
    always_ff @(posedge CLK) begin
        if (!RST && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty
    always_ff @(posedge CLK) begin
        if (RST || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_prefetch_buffer.sv
// rtl/inst_prefetch_buffer.sv - sequential instruction prefetcher feeding the core through a small FIFO
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int                DEPTH    = DEPTH_DEFAULT,
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    output logic                    I_MEM_CSN,
    output logic [ADDR_W-1:0]       I_MEM_ADDR,
    input  logic [31:0]             I_MEM_DI,
    output logic                    INST_VALID,
    output logic [31:0]             INST,
    output logic [ADDR_W-1:0]       INST_PC,
    input  logic                    INST_READY,
    input  logic                    REDIRECT,
    input  logic [ADDR_W-1:0]       REDIRECT_PC,
    output logic [ptr_w(DEPTH):0]   COUNT
);

    localparam int CW = ptr_w(DEPTH) + 1;

    logic [ADDR_W-1:0]  fetch_pc_q;
    logic [ADDR_W-1:0]  fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q;
    logic [ADDR_W-1:0]  req_pc_d;
    logic               inflight_q;
    logic               inflight_d;
    logic [CW-1:0]      count;
    logic [CW:0]        credit_used;
    logic               issue;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic [31+ADDR_W:0] head_data;

    // A slot is reserved for every outstanding request; a same-cycle pop earns no credit
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue       = !RST && !REDIRECT && (credit_used < (CW+1)'(DEPTH));

    assign I_MEM_CSN  = !issue;
    assign I_MEM_ADDR = RST ? RESET_PC : fetch_pc_q;

    // Fetch address and outstanding-request tracking; redirect takes priority over issue
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (REDIRECT) begin
            fetch_pc_d = REDIRECT_PC & ~ADDR_W'(3);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            req_pc_d   = fetch_pc_q;
            inflight_d = 1'b1;
        end
    end

    // Fetch state registers with synchronous reset to the boot address
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // A response landing during a redirect belongs to the abandoned path and is dropped
    assign push = inflight_q && !REDIRECT;
    assign pop  = head_valid && INST_READY && !REDIRECT;

    inst_fifo #(
        .DEPTH (DEPTH),
        .W     (32 + ADDR_W)
    ) u_fifo (
        .CLK          (CLK),
        .RST          (RST),
        .push_i       (push),
        .push_data_i  ({I_MEM_DI, req_pc_q}),
        .pop_i        (pop),
        .flush_i      (REDIRECT),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_data_o  (head_data)
    );

    assign INST_VALID = head_valid;
    assign INST       = head_data[31+ADDR_W:ADDR_W];
    assign INST_PC    = head_data[ADDR_W-1:0];
    assign COUNT      = count;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb/tb_inst_prefetch_buffer.sv - self-checking bench for inst_prefetch_buffer against a queue model
module tb_inst_prefetch_buffer;
    import inst_prefetch_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          I_MEM_CSN;
    logic [AW-1:0] I_MEM_ADDR;
    logic [31:0]   I_MEM_DI;
    logic          INST_VALID;
    logic [31:0]   INST;
    logic [AW-1:0] INST_PC;
    logic          INST_READY;
    logic          REDIRECT;
    logic [AW-1:0] REDIRECT_PC;
    logic [CW-1:0] COUNT;

    always #5 CLK = ~CLK;

    inst_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .RESET_PC (12'h000)
    ) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .I_MEM_CSN   (I_MEM_CSN),
        .I_MEM_ADDR  (I_MEM_ADDR),
        .I_MEM_DI    (I_MEM_DI),
        .INST_VALID  (INST_VALID),
        .INST        (INST),
        .INST_PC     (INST_PC),
        .INST_READY  (INST_READY),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .COUNT       (COUNT)
    );

    // Synchronous SRAM: word = 0x1000_0000 | address, poison when not selected
    int            n_req = 0;
    logic [AW-1:0] last_addr = '0;
    always @(posedge CLK) begin
        if (!I_MEM_CSN) begin
            I_MEM_DI  <= 32'h1000_0000 | {20'h0, I_MEM_ADDR};
            last_addr <= I_MEM_ADDR;
            n_req     <= n_req + 1;
        end else begin
            I_MEM_DI  <= 32'hDEAD_BEEF;
        end
    end

    // Reference model: a queue of buffered entries, one pending request, the next fetch address
    entry_t        mq[$];
    bit            m_pend;
    logic [AW-1:0] m_pend_pc;
    logic [AW-1:0] m_fetch;
    bit            known = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit exp_issue;
        if (!known) return;
        exp_issue = !RST && !REDIRECT && ((mq.size() + int'(m_pend)) < DEPTH);
        cmp("csn",   {31'h0, I_MEM_CSN}, {31'h0, !exp_issue});
        cmp("addr",  {20'h0, I_MEM_ADDR}, RST ? 32'h0 : {20'h0, m_fetch});
        cmp("valid", {31'h0, INST_VALID}, {31'h0, mq.size() > 0});
        cmp("count", 32'(COUNT), 32'(mq.size()));
        if (mq.size() > 0) begin
            cmp("inst",    INST, mq[0].inst);
            cmp("inst_pc", {20'h0, INST_PC}, {20'h0, mq[0].pc});
        end
        if (!RST && !REDIRECT && u_dut.inflight_q) begin
            cmp("no_overflow", {31'h0, COUNT < CW'(DEPTH)}, 32'h1);
        end
    endtask

    task automatic model_update(input logic r, input logic rd, input logic [AW-1:0] rpc, input logic rdy);
        bit iss;
        if (r) begin
            mq.delete();
            m_pend  = 1'b0;
            m_fetch = 12'h000;
            known   = 1'b1;
        end else if (rd) begin
            mq.delete();
            m_pend  = 1'b0;
            m_fetch = {rpc[AW-1:2], 2'b00};
        end else begin
            iss = (mq.size() + int'(m_pend)) < DEPTH;
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (m_pend) mq.push_back('{inst: 32'h1000_0000 | {20'h0, m_pend_pc}, pc: m_pend_pc});
            if (iss) begin
                m_pend    = 1'b1;
                m_pend_pc = m_fetch;
                m_fetch   = m_fetch + 12'd4;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive at negedge, compare, advance model, return at next negedge
    task automatic step(input logic r, input logic rd, input logic [AW-1:0] rpc, input logic rdy);
        RST         = r;
        REDIRECT    = rd;
        REDIRECT_PC = rpc;
        INST_READY  = rdy;
        #1;
        check_outputs();
        model_update(r, rd, rpc, rdy);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            r0;
        int            maxc;
        int            nvalid;
        logic [AW-1:0] pcs[$];
        logic [AW-1:0] wrap_exp [4];

        RST = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = '0; INST_READY = 1'b0;

        // Streaming
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        cmp("rst_valid", {31'h0, INST_VALID}, 32'h0);
        cmp("rst_count", 32'(COUNT), 32'h0);
        cmp("rst_csn",   {31'h0, I_MEM_CSN}, 32'h1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        cmp("stream_valid_c2", {31'h0, INST_VALID}, 32'h1);
        cmp("stream_pc_c2",    {20'h0, INST_PC}, 32'h0);
        cmp("stream_inst_c2",  INST, 32'h1000_0000);
        maxc = 0; nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1);
            if (int'(COUNT) > maxc) maxc = int'(COUNT);
            if (INST_VALID) nvalid++;
        end
        cmp("stream_max_count", 32'(maxc), 32'd1);
        cmp("stream_rate",      32'(nvalid), 32'd10);

        // Backpressure from reset
        step(1, 0, 0, 0);
        r0 = n_req;
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        cmp("bp_requests",  32'(n_req - r0), 32'd4);
        cmp("bp_count",     32'(COUNT), 32'd4);
        cmp("bp_csn",       {31'h0, I_MEM_CSN}, 32'h1);
        cmp("bp_last_addr", {20'h0, last_addr}, 32'h00C);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        cmp("bp_next_addr", {20'h0, last_addr}, 32'h010);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Redirect while streaming
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 1, 12'h123, 1);
        cmp("redir_count", 32'(COUNT), 32'h0);
        cmp("redir_addr",  {20'h0, I_MEM_ADDR}, 32'h120);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        cmp("redir_valid_t3", {31'h0, INST_VALID}, 32'h1);
        cmp("redir_pc_t3",    {20'h0, INST_PC}, 32'h120);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Redirect with full FIFO and ready, then reset together with redirect
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        cmp("full_count", 32'(COUNT), 32'd4);
        step(0, 1, 12'h040, 1);
        cmp("flush_count", 32'(COUNT), 32'h0);
        step(1, 1, 12'h200, 0);
        cmp("rst_redir_count", 32'(COUNT), 32'h0);
        cmp("rst_redir_addr",  {20'h0, I_MEM_ADDR}, 32'h0);
        step(0, 0, 0, 1);
        cmp("rst_redir_fetch", {20'h0, last_addr}, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Address wrap-around
        step(0, 1, 12'hFF8, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1);
            if (INST_VALID) pcs.push_back(INST_PC);
        end
        wrap_exp[0] = 12'hFF8; wrap_exp[1] = 12'hFFC; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h004;
        cmp("wrap_n", {31'h0, pcs.size() >= 4}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i < pcs.size()) cmp("wrap_pc", {20'h0, pcs[i]}, {20'h0, wrap_exp[i]});
        end

        // Reset with COUNT=3 and a request in flight
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        cmp("mid_count_pre", 32'(COUNT), 32'd3);
        step(1, 0, 0, 0);
        cmp("mid_valid", {31'h0, INST_VALID}, 32'h0);
        cmp("mid_count", 32'(COUNT), 32'h0);
        step(0, 0, 0, 1);
        cmp("mid_restart", {20'h0, last_addr}, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
